// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register-file / ALU datapath.
package reg_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // ADD and SUB are the only functions that produce a meaningful carry.
  function automatic logic op_sets_carry(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 4-function ALU; c is bit WIDTH of the (WIDTH+1)-bit sum.
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff;
  logic             c_in;

  // SUB is A + ~B + 1, so carry-out of 1 means no borrow.
  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    c_in  = (op == OP_SUB);
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
  end

  // Function select; carry is zero for the logic ops.
  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// Register file plus ALU with a single registered write-back stage.
// A pending write-back is forwarded to the read ports, so a dependent op
// issued the very next cycle sees the new value with no stall.
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             sel,
  input  logic             wr,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out_a,
  output logic [WIDTH-1:0] d_out_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic             wb_wr_q, wb_wr_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             commit;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  assign commit = result_valid_q & wb_wr_q;

  // Read ports with forwarding from the write-back stage.
  always_comb begin
    d_out_a = regs_q[rd_addr_a];
    d_out_b = regs_q[rd_addr_b];
    if (commit && (wb_addr_q == rd_addr_a)) d_out_a = result_q;
    if (commit && (wb_addr_q == rd_addr_b)) d_out_b = result_q;
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op(op),
    .a (d_out_a),
    .b (d_out_b),
    .y (alu_y),
    .c (alu_c)
  );

  // Register-file commit uses the write-back contents present before this edge.
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (commit) regs_d[wb_addr_q] = result_q;
  end

  // Issue: load the write-back stage and update flags on ALU-sourced issues.
  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    wb_addr_d      = wb_addr_q;
    wb_wr_d        = wb_wr_q;
    cout_d         = cout_q;
    zero_d         = zero_q;
    if (in_valid) begin
      result_d       = sel ? alu_y : d_in;
      result_valid_d = 1'b1;
      wb_addr_d      = wr_addr;
      wb_wr_d        = wr;
      if (sel) begin
        zero_d = (alu_y == '0);
        if (op_sets_carry(op)) cout_d = alu_c;
      end
    end
  end

  // State update; reset discards any pending write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      wb_addr_q      <= '0;
      wb_wr_q        <= 1'b0;
      cout_q         <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      wb_addr_q      <= wb_addr_d;
      wb_wr_q        <= wb_wr_d;
      cout_q         <= cout_d;
      zero_q         <= zero_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign cout         = cout_q;
  assign zero         = zero_q;

endmodule
